// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and stall controller for a classic five-stage in-order pipeline.
// It produces the load enables and bubble (flush) controls of the pipeline
// registers from three hazard sources, highest priority first:
//   1. data-memory wait  : freeze the whole pipeline until MEM_ready
//   2. taken branch/jump : squash the two younger instructions (IF/ID, ID/EX)
//   3. load-use hazard   : hold PC and IF/ID once, insert one bubble into EX
// It also counts front-end stall cycles and raises a sticky flag when a
// memory access waits TIMEOUT cycles.
//
// Parameters
//   TIMEOUT         memory-wait cycles before mem_timeout sets (8-bit)
//   CNT_W           width of the stall-cycle counter
// Ports
//   clk             clock, all state updates on its rising edge
//   reset           synchronous reset, active low
//   ID_rs1/ID_rs2   source register indices of the instruction in ID
//   ID_uses_rs2     the ID instruction actually reads rs2
//   EX_Rd           destination register of the instruction in EX
//   EX_mem_read     the EX instruction is a load
//   EX_branch_taken EX resolved a taken branch or jump
//   MEM_req         MEM stage is accessing data memory
//   MEM_ready       data memory completes the access this cycle
//   *_en            pipeline-register / PC load enables
//   IF_ID_flush     load a bubble into IF/ID
//   ID_EX_flush     load a bubble into ID/EX
//   stall_cycles    saturating count of cycles with PC_en=0 since reset
//   mem_timeout     sticky memory-wait timeout flag
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter logic [7:0]  TIMEOUT = 8'd200,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_uses_rs2,
    input  logic [4:0]       EX_Rd,
    input  logic             EX_mem_read,
    input  logic             EX_branch_taken,
    input  logic             MEM_req,
    input  logic             MEM_ready,
    output logic             PC_en,
    output logic             IF_ID_en,
    output logic             ID_EX_en,
    output logic             EX_MEM_en,
    output logic             MEM_WB_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic             lu_stall_q, lu_stall_d;   // previous cycle was a load-use stall
    logic [CNT_W-1:0] stall_cnt_q;

    logic load_use;
    logic mem_stall;

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = EX_mem_read && (EX_Rd != 5'd0) &&
                      ((EX_Rd == ID_rs1) || (ID_uses_rs2 && (EX_Rd == ID_rs2)));

    // Once waiting, only MEM_ready releases the freeze, even if MEM_req drops.
    assign mem_stall = (state_q == MEM_WAIT) ? !MEM_ready : (MEM_req && !MEM_ready);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        PC_en         = 1'b1;
        IF_ID_en      = 1'b1;
        ID_EX_en      = 1'b1;
        EX_MEM_en     = 1'b1;
        MEM_WB_en     = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_flush   = 1'b0;
        state_d       = RUN;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        lu_stall_d    = 1'b0;

        if (!reset) begin
            PC_en       = 1'b0;
            IF_ID_en    = 1'b0;
            ID_EX_en    = 1'b0;
            EX_MEM_en   = 1'b0;
            MEM_WB_en   = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (mem_stall) begin
            // A branch seen here is not lost: EX is frozen, so it is still
            // presented on the release cycle and flushes then.
            PC_en     = 1'b0;
            IF_ID_en  = 1'b0;
            ID_EX_en  = 1'b0;
            EX_MEM_en = 1'b0;
            MEM_WB_en = 1'b0;
            state_d   = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                wait_cnt_d = 8'd0;
            end else begin
                if (wait_cnt_q != TIMEOUT) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
                // NOTE: blocking assignments in always_comb, so wait_cnt_d here
                // is the value just computed above, not last cycle's.
                mem_timeout_d = mem_timeout_q | (wait_cnt_d == TIMEOUT);
            end
        end else if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            state_d     = FLUSH;
        end else if ((state_q == RUN) && !lu_stall_q && load_use) begin
            // The bubble just inserted sits in EX next cycle; refusing a second
            // stall back-to-back guarantees one bubble per load.
            PC_en       = 1'b0;
            IF_ID_en    = 1'b0;
            ID_EX_flush = 1'b1;
            lu_stall_d  = 1'b1;
        end
    end

    // NOTE: reset is synchronous: it is only looked at on the clock edge, and
    // state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            lu_stall_q    <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            lu_stall_q    <= lu_stall_d;
            if (!PC_en && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl. A behavioural model keeps
// a few facts about pipeline history (waiting on memory, just redirected,
// just inserted a load-use bubble, wait length, stall total) and derives the
// expected controls from the priority rules. Directed scenarios are followed
// by a randomized run. Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam logic [7:0] TO    = 8'd4;
    localparam int         CNT_W = 16;
    localparam int         CMAX  = (1 << CNT_W) - 1;

    // Output vector layout: {PC,IF_ID,ID_EX,EX_MEM,MEM_WB enables, IF_ID_flush, ID_EX_flush}
    localparam logic [6:0] V_RUN    = 7'b1111100;
    localparam logic [6:0] V_LU     = 7'b0011101;
    localparam logic [6:0] V_BRANCH = 7'b1111111;
    localparam logic [6:0] V_MEM    = 7'b0000000;
    localparam logic [6:0] V_RESET  = 7'b0000011;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       ID_rs1, ID_rs2, EX_Rd;
    logic             ID_uses_rs2, EX_mem_read, EX_branch_taken, MEM_req, MEM_ready;
    logic             PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
    logic             IF_ID_flush, ID_EX_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_timeout;
    logic [6:0]       dut_vec;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic m_waiting;   // memory access outstanding, pipeline frozen
    logic m_redirect;  // previous cycle squashed younger instructions
    logic m_lu_last;   // previous cycle inserted a load-use bubble
    logic m_timeout;
    int   m_wait_len;
    int   m_stalls;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_rs1          (ID_rs1),
        .ID_rs2          (ID_rs2),
        .ID_uses_rs2     (ID_uses_rs2),
        .EX_Rd           (EX_Rd),
        .EX_mem_read     (EX_mem_read),
        .EX_branch_taken (EX_branch_taken),
        .MEM_req         (MEM_req),
        .MEM_ready       (MEM_ready),
        .PC_en           (PC_en),
        .IF_ID_en        (IF_ID_en),
        .ID_EX_en        (ID_EX_en),
        .EX_MEM_en       (EX_MEM_en),
        .MEM_WB_en       (MEM_WB_en),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_flush     (ID_EX_flush),
        .stall_cycles    (stall_cycles),
        .mem_timeout     (mem_timeout)
    );

    assign dut_vec = {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush};

    // ---------------- reference model ----------------
    function automatic logic mdl_mem_busy();
        return m_waiting ? !MEM_ready : (MEM_req && !MEM_ready);
    endfunction

    function automatic logic mdl_dep();
        return EX_mem_read && (EX_Rd != 0) &&
               ((EX_Rd == ID_rs1) || (ID_uses_rs2 && (EX_Rd == ID_rs2)));
    endfunction

    function automatic logic [6:0] model_out();
        if (!reset)                                         return V_RESET;
        if (mdl_mem_busy())                                 return V_MEM;
        if (EX_branch_taken)                                return V_BRANCH;
        if (!m_waiting && !m_redirect && !m_lu_last && mdl_dep()) return V_LU;
        return V_RUN;
    endfunction

    task automatic model_advance();
        logic [6:0] o;
        o = model_out();
        if (!reset) begin
            m_waiting = 0; m_redirect = 0; m_lu_last = 0;
            m_timeout = 0; m_wait_len = 0; m_stalls = 0;
        end else begin
            if (!o[6] && m_stalls < CMAX) m_stalls++;
            if (mdl_mem_busy()) begin
                if (m_waiting) begin
                    if (m_wait_len < int'(TO)) m_wait_len++;
                    if (m_wait_len == int'(TO)) m_timeout = 1;
                end else begin
                    m_wait_len = 0;
                end
                m_waiting  = 1;
                m_redirect = 0;
                m_lu_last  = 0;
            end else begin
                m_waiting  = 0;
                m_redirect = EX_branch_taken;
                m_lu_last  = (o == V_LU);
            end
        end
    endtask

    // Advance one clock: model tracks the edge, inputs may change 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_idle();
        ID_rs1 = 5'd1; ID_rs2 = 5'd2; ID_uses_rs2 = 1'b0;
        EX_Rd = 5'd0; EX_mem_read = 1'b0; EX_branch_taken = 1'b0;
        MEM_req = 1'b0; MEM_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        set_idle();
        MEM_req = 1'b1;
        m_waiting = 0; m_redirect = 0; m_lu_last = 0;
        m_timeout = 0; m_wait_len = 0; m_stalls = 0;
        @(negedge clk);
        checks++;
        if (dut_vec !== V_RESET) begin
            errors++; $display("FAIL reset_outputs: got %b want %b", dut_vec, V_RESET);
        end
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (stall_cycles !== 0 || mem_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_state: stall_cycles=%0d mem_timeout=%b want 0/0",
                               stall_cycles, mem_timeout);
        end
        reset = 1'b1;
        set_idle();
        @(negedge clk);
        checks++;
        if (dut_vec !== model_out()) begin
            errors++; $display("FAIL run_default: got %b want %b", dut_vec, model_out());
        end
        tick();
    endtask

    task automatic test_load_use();
        EX_mem_read = 1'b1; EX_Rd = 5'd5; ID_rs1 = 5'd5;
        @(negedge clk);
        checks++;
        if (dut_vec !== V_LU || dut_vec !== model_out()) begin
            errors++; $display("FAIL load_use_stall: got %b want %b", dut_vec, V_LU);
        end
        tick();
        // Dependency still presented: only one bubble is allowed per load.
        @(negedge clk);
        checks++;
        if (dut_vec !== model_out()) begin
            errors++; $display("FAIL load_use_single: got %b want %b", dut_vec, model_out());
        end
        checks++;
        if (stall_cycles !== 1) begin
            errors++; $display("FAIL load_use_count: got %0d want 1", stall_cycles);
        end
        tick();
        set_idle();
        tick();
    endtask

    task automatic test_no_hazard();
        EX_mem_read = 1'b1; EX_Rd = 5'd0; ID_rs1 = 5'd0;
        @(negedge clk);
        checks++;
        if (dut_vec !== V_RUN || dut_vec !== model_out()) begin
            errors++; $display("FAIL r0_no_stall: got %b want %b", dut_vec, V_RUN);
        end
        tick();
        EX_Rd = 5'd7; ID_rs1 = 5'd3; ID_rs2 = 5'd7; ID_uses_rs2 = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_vec !== V_RUN || dut_vec !== model_out()) begin
            errors++; $display("FAIL rs2_unused: got %b want %b", dut_vec, V_RUN);
        end
        tick();
        ID_uses_rs2 = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_vec !== V_LU || dut_vec !== model_out()) begin
            errors++; $display("FAIL rs2_used: got %b want %b", dut_vec, V_LU);
        end
        tick();
        set_idle();
        tick();
    endtask

    task automatic test_branch_flush();
        EX_branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_vec !== V_BRANCH || dut_vec !== model_out()) begin
            errors++; $display("FAIL branch_flush: got %b want %b", dut_vec, V_BRANCH);
        end
        tick();
        EX_branch_taken = 1'b0;
        EX_mem_read = 1'b1; EX_Rd = 5'd9; ID_rs1 = 5'd9;
        @(negedge clk);
        checks++;
        if (dut_vec !== V_RUN || dut_vec !== model_out()) begin
            errors++; $display("FAIL flush_suppress_lu: got %b want %b", dut_vec, V_RUN);
        end
        tick();
        @(negedge clk);
        checks++;
        if (dut_vec !== V_LU || dut_vec !== model_out()) begin
            errors++; $display("FAIL flush_back_to_run: got %b want %b", dut_vec, V_LU);
        end
        tick();
        set_idle();
        tick();
    endtask

    task automatic test_mem_stall();
        int base;
        base = m_stalls;
        MEM_req = 1'b1; MEM_ready = 1'b0; EX_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== V_MEM || dut_vec !== model_out()) begin
                errors++; $display("FAIL mem_wait_%0d: got %b want %b", i, dut_vec, V_MEM);
            end
            tick();
        end
        MEM_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_vec !== V_BRANCH || dut_vec !== model_out()) begin
            errors++; $display("FAIL mem_release_branch: got %b want %b", dut_vec, V_BRANCH);
        end
        checks++;
        if (int'(stall_cycles) !== base + 3) begin
            errors++; $display("FAIL mem_stall_count: got %0d want %0d", stall_cycles, base + 3);
        end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (dut_vec !== model_out()) begin
            errors++; $display("FAIL post_release: got %b want %b", dut_vec, model_out());
        end
        tick();
    endtask

    task automatic test_timeout();
        MEM_req = 1'b1; MEM_ready = 1'b0;
        tick();                                   // RUN cycle that enters MEM_WAIT
        for (int j = 1; j <= 5; j++) begin        // j-1 waiting cycles completed
            @(negedge clk);
            checks++;
            if (mem_timeout !== ((j - 1) >= int'(TO)) || mem_timeout !== m_timeout) begin
                errors++; $display("FAIL timeout_wait_%0d: got %b want %b",
                                   j - 1, mem_timeout, ((j - 1) >= int'(TO)));
            end
            tick();
        end
        MEM_ready = 1'b1;
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (mem_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: got %b want 1", mem_timeout);
        end
        // Enter a fresh wait, then reset in the middle of it.
        MEM_req = 1'b1; MEM_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_vec !== V_RESET) begin
            errors++; $display("FAIL reset_mid_wait: got %b want %b", dut_vec, V_RESET);
        end
        tick();
        reset = 1'b1;
        MEM_req = 1'b0; MEM_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_timeout !== 1'b0 || stall_cycles !== 0) begin
            errors++; $display("FAIL reset_clears: mem_timeout=%b stall_cycles=%0d want 0/0",
                               mem_timeout, stall_cycles);
        end
        checks++;
        if (dut_vec !== V_RUN) begin
            errors++; $display("FAIL wait_abandoned: got %b want %b", dut_vec, V_RUN);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset           = ($urandom_range(0, 49) != 0);
            ID_rs1          = 5'($urandom_range(0, 3));
            ID_rs2          = 5'($urandom_range(0, 3));
            EX_Rd           = 5'($urandom_range(0, 3));
            ID_uses_rs2     = 1'($urandom_range(0, 1));
            EX_mem_read     = ($urandom_range(0, 2) != 0);
            EX_branch_taken = ($urandom_range(0, 7) == 0);
            MEM_req         = ($urandom_range(0, 3) == 0);
            MEM_ready       = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            checks++;
            if (dut_vec !== model_out()) begin
                errors++; $display("FAIL rand_ctrl[%0d]: got %b want %b", n, dut_vec, model_out());
            end
            checks++;
            if (int'(stall_cycles) !== m_stalls || mem_timeout !== m_timeout) begin
                errors++; $display("FAIL rand_state[%0d]: stall=%0d tmo=%b want %0d/%b",
                                   n, stall_cycles, mem_timeout, m_stalls, m_timeout);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_flush();
        test_mem_stall();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
